mlp_train_seq: RTL and testbench

MLP_TRAIN_SEQ -- requirements
Module: mlp_train_seq

---
 rtl/mlp_pkg.sv | 29 ++
 rtl/mlp_sample_mem.sv | 31 +++
 rtl/mlp_train_seq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mlp_train_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types for the MLP training sequencer: Q8.8 values, sample payload,
// FSM state encoding and the binary classification helper.
package mlp_pkg;

  typedef logic [15:0] q8_8_t;

  localparam q8_8_t Q_HALF = 16'h0080;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRAIN  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TEST   = 3'd3,
    ST_EVAL   = 3'd4,
    ST_DONE   = 3'd5
  } mlp_state_e;

  typedef struct packed {
    q8_8_t x1;
    q8_8_t x2;
    q8_8_t y;
  } mlp_sample_t;

  // Class 1 when strictly above one half (unsigned compare).
  function automatic logic q_class(input q8_8_t v);
    return v > Q_HALF;
  endfunction

endpackage

// File: rtl/mlp_sample_mem.sv
// Training sample store: DEPTH x 48-bit register array, one synchronous
// write port and one combinational read port. Contents are not reset.
// Ports: clk; we_i/waddr_i/wdata_i write port (out-of-range addresses
// dropped); raddr_i/rdata_o read port.
module mlp_sample_mem
  import mlp_pkg::*;
#(
  parameter int unsigned DEPTH = 10
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  mlp_sample_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output mlp_sample_t                rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  mlp_sample_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i <= LAST_ADDR)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mlp_train_seq.sv
// MLP training sequencer: loads samples in IDLE, replays them to the network
// for EPOCHS passes, settles one cycle, applies a captured test vector and
// classifies the response. Optional macro MLP_TRAIN_SEQ_EVAL_EN adds an EVAL
// pass that counts misclassified stored samples into err_count.
// Ports: clk/rst (sync, active-high); wr_* sample load; start + test_* run
// request; y_out network response; mlp_* network drive; busy/done/pass/
// y_result/err_count status. All outputs are registered.
module mlp_train_seq
  import mlp_pkg::*;
#(
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned EPOCHS   = 30,
  parameter int unsigned TEST_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [15:0]              wr_x1,
  input  logic [15:0]              wr_x2,
  input  logic [15:0]              wr_y,
  input  logic                     start,
  input  logic [15:0]              test_x1,
  input  logic [15:0]              test_x2,
  input  logic [15:0]              test_y,
  input  logic [15:0]              y_out,
  output logic                     mlp_train,
  output logic [15:0]              mlp_x1,
  output logic [15:0]              mlp_x2,
  output logic [15:0]              mlp_y_target,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              y_result,
  output logic [7:0]               err_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned EP_W   = $clog2(EPOCHS + 1);
  localparam int unsigned WAIT_W = 4;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [EP_W-1:0]   LAST_EPOCH = EP_W'(EPOCHS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(TEST_LAT - 1);

  mlp_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [EP_W-1:0]   epoch_q, epoch_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  mlp_sample_t       test_q, test_d;
  logic              train_q, train_d;
  q8_8_t             x1_q, x1_d, x2_q, x2_d, yt_q, yt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  q8_8_t             yres_q, yres_d;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
  logic [7:0]        err_q, err_d;
`endif

  logic              we_c;
  logic [IDX_W-1:0]  raddr_c;
  mlp_sample_t       wdata_c, mem_rd_c, rd_c;

  assign we_c    = wr_en && (state_q == ST_IDLE);
  assign wdata_c = '{x1: wr_x1, x2: wr_x2, y: wr_y};

  mlp_sample_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (wr_addr),
    .wdata_i (wdata_c),
    .raddr_i (raddr_c),
    .rdata_o (mem_rd_c)
  );

  // Address of the sample the next edge will drive (derived from current state only).
  always_comb begin
    raddr_c = '0;
    if (state_q == ST_TRAIN || state_q == ST_EVAL) begin
      raddr_c = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // A write coinciding with start must be seen by the first train cycle.
  assign rd_c = (we_c && (wr_addr == raddr_c)) ? wdata_c : mem_rd_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    epoch_d = epoch_q;
    wait_d  = wait_q;
    test_d  = test_q;
    train_d = train_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    yt_d    = yt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    yres_d  = yres_q;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_TRAIN;
          idx_d   = '0;
          epoch_d = '0;
          test_d  = '{x1: test_x1, x2: test_x2, y: test_y};
          train_d = 1'b1;
          x1_d    = rd_c.x1;
          x2_d    = rd_c.x2;
          yt_d    = rd_c.y;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          yres_d  = '0;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
          err_d   = '0;
`endif
        end
      end

      ST_TRAIN: begin
        if (idx_q == LAST_IDX && epoch_q == LAST_EPOCH) begin
          // Final sample of the final epoch: hold inputs, drop train.
          state_d = ST_SETTLE;
          train_d = 1'b0;
        end else begin
          idx_d = raddr_c;
          if (idx_q == LAST_IDX) begin
            epoch_d = epoch_q + 1'b1;
          end
          x1_d = rd_c.x1;
          x2_d = rd_c.x2;
          yt_d = rd_c.y;
        end
      end

      ST_SETTLE: begin
        state_d = ST_TEST;
        wait_d  = '0;
        x1_d    = test_q.x1;
        x2_d    = test_q.x2;
        yt_d    = '0;
      end

      ST_TEST: begin
        if (wait_q == LAST_WAIT) begin
          yres_d = y_out;
          pass_d = (q_class(y_out) == q_class(test_q.y));
          wait_d = '0;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
          state_d = ST_EVAL;
          idx_d   = '0;
          x1_d    = rd_c.x1;
          x2_d    = rd_c.x2;
          yt_d    = rd_c.y;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
          x1_d    = '0;
          x2_d    = '0;
`endif
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

`ifdef MLP_TRAIN_SEQ_EVAL_EN
      ST_EVAL: begin
        if (wait_q == LAST_WAIT) begin
          wait_d = '0;
          // yt_q holds the stored label of the sample being evaluated.
          if (q_class(y_out) != q_class(yt_q) && err_q != 8'hFF) begin
            err_d = err_q + 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            x1_d    = '0;
            x2_d    = '0;
            yt_d    = '0;
          end else begin
            idx_d = raddr_c;
            x1_d  = rd_c.x1;
            x2_d  = rd_c.x2;
            yt_d  = rd_c.y;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        train_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      epoch_q <= '0;
      wait_q  <= '0;
      test_q  <= '0;
      train_q <= 1'b0;
      x1_q    <= '0;
      x2_q    <= '0;
      yt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      yres_q  <= '0;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      wait_q  <= wait_d;
      test_q  <= test_d;
      train_q <= train_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      yt_q    <= yt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      yres_q  <= yres_d;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mlp_train    = train_q;
  assign mlp_x1       = x1_q;
  assign mlp_x2       = x2_q;
  assign mlp_y_target = yt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign y_result     = yres_q;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
  assign err_count    = err_q;
`else
  assign err_count    = 8'h00;
`endif

endmodule

// File: tb/tb_mlp_train_seq.sv
// Self-checking bench for mlp_train_seq (DEPTH=4, EPOCHS=3, TEST_LAT=1).
// Expected drive sequences, pass and error counts come from a plain array
// model of the loaded samples and the classification rule.
module tb_mlp_train_seq;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned EPOCHS   = 3;
  localparam int unsigned TEST_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_x1, wr_x2, wr_y;
  logic        start;
  logic [15:0] test_x1, test_x2, test_y;
  logic [15:0] y_out;
  logic        mlp_train;
  logic [15:0] mlp_x1, mlp_x2, mlp_y_target;
  logic        busy, done, pass;
  logic [15:0] y_result;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mx1 [DEPTH];
  logic [15:0] mx2 [DEPTH];
  logic [15:0] my  [DEPTH];

  mlp_train_seq #(.DEPTH(DEPTH), .EPOCHS(EPOCHS), .TEST_LAT(TEST_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_x1        (wr_x1),
    .wr_x2        (wr_x2),
    .wr_y         (wr_y),
    .start        (start),
    .test_x1      (test_x1),
    .test_x2      (test_x2),
    .test_y       (test_y),
    .y_out        (y_out),
    .mlp_train    (mlp_train),
    .mlp_x1       (mlp_x1),
    .mlp_x2       (mlp_x2),
    .mlp_y_target (mlp_y_target),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .y_result     (y_result),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit cls(input logic [15:0] v);
    return v > 16'd128;
  endfunction

  task automatic load(input int a, input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] y);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'(a); wr_x1 = x1; wr_x2 = x2; wr_y = y;
    mx1[a] = x1; mx2[a] = x2; my[a] = y;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One complete run; noise injects ignored start/wr_en/test changes during
  // training, cw places a write on the same edge as start.
  task automatic run(input logic [15:0] tx1, input logic [15:0] tx2, input logic [15:0] ty,
                     input logic [15:0] ys, input bit noise, input bit cw);
    int   exp_err;
    bit   exp_pass;
    int   a;
    exp_pass = (cls(ys) == cls(ty));
    @(negedge clk);
    test_x1 = tx1; test_x2 = tx2; test_y = ty; y_out = ys; start = 1'b1;
    if (cw) begin
      a = $urandom_range(0, DEPTH - 1);
      wr_en = 1'b1; wr_addr = 2'(a);
      wr_x1 = 16'($urandom); wr_x2 = 16'($urandom); wr_y = 16'($urandom);
      mx1[a] = wr_x1; mx2[a] = wr_x2; my[a] = wr_y;
    end
    for (int k = 0; k < DEPTH * EPOCHS; k++) begin
      @(negedge clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        wr_addr = 2'($urandom); wr_x1 = 16'($urandom); wr_x2 = 16'($urandom); wr_y = 16'($urandom);
        test_x1 = 16'($urandom); test_y = 16'($urandom);
      end
      check("train_en", 32'(mlp_train), 32'd1);
      check("train_busy", 32'(busy), 32'd1);
      check("train_x1", 32'(mlp_x1), 32'(mx1[k % DEPTH]));
      check("train_x2", 32'(mlp_x2), 32'(mx2[k % DEPTH]));
      check("train_yt", 32'(mlp_y_target), 32'(my[k % DEPTH]));
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check("settle_en", 32'(mlp_train), 32'd0);
    check("settle_x1", 32'(mlp_x1), 32'(mx1[DEPTH - 1]));
    check("settle_yt", 32'(mlp_y_target), 32'(my[DEPTH - 1]));
    check("settle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("test_en", 32'(mlp_train), 32'd0);
    check("test_x1", 32'(mlp_x1), 32'(tx1));
    check("test_x2", 32'(mlp_x2), 32'(tx2));
    check("test_yt", 32'(mlp_y_target), 32'd0);
    check("test_done", 32'(done), 32'd0);
    exp_err = 0;
`ifdef MLP_TRAIN_SEQ_EVAL_EN
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      check("eval_en", 32'(mlp_train), 32'd0);
      check("eval_x1", 32'(mlp_x1), 32'(mx1[j]));
      check("eval_x2", 32'(mlp_x2), 32'(mx2[j]));
      if (cls(ys) != cls(my[j])) exp_err++;
    end
`endif
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("y_result", 32'(y_result), 32'(ys));
    check("pass", 32'(pass), 32'(exp_pass));
    check("err_count", 32'(err_count), 32'(exp_err));
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("hold_pass", 32'(pass), 32'(exp_pass));
    check("hold_yres", 32'(y_result), 32'(ys));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0; wr_y = '0;
    start = 1'b0; test_x1 = '0; test_x2 = '0; test_y = '0; y_out = '0;
    repeat (3) @(negedge clk);
    check("rst_train", 32'(mlp_train), 32'd0);
    check("rst_x1", 32'(mlp_x1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_yres", 32'(y_result), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    rst = 1'b0;

    // XOR-like data set.
    load(0, 16'h0000, 16'h0000, 16'h0000);
    load(1, 16'h0000, 16'h0100, 16'h0100);
    load(2, 16'h0100, 16'h0000, 16'h0100);
    load(3, 16'h0100, 16'h0100, 16'h0000);

    run(16'h0100, 16'h0000, 16'h0000, 16'h0040, 1'b0, 1'b0);
    run(16'h0100, 16'h0000, 16'h0000, 16'h0081, 1'b0, 1'b0);
    run(16'h0000, 16'h0100, 16'h0080, 16'h0080, 1'b0, 1'b0);
    run(16'h0000, 16'h0100, 16'h0080, 16'h0081, 1'b0, 1'b0);
    run(16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0);
    run(16'h0123, 16'h0456, 16'h0100, 16'h007F, 1'b1, 1'b0);

    // Abort mid-training, then replay the retained samples.
    @(negedge clk);
    start = 1'b1; test_x1 = 16'h0011; test_x2 = 16'h0022; test_y = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_train", 32'(mlp_train), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_x1", 32'(mlp_x1), 32'd0);
    @(negedge clk);
    check("abort_done2", 32'(done), 32'd0);
    check("abort_busy2", 32'(busy), 32'd0);
    run(16'h0011, 16'h0022, 16'h0000, 16'h0010, 1'b0, 1'b0);

    run(16'h0033, 16'h0044, 16'h0090, 16'h00A0, 1'b0, 1'b1);

    for (int i = 0; i < DEPTH; i++)
      load(i, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h0180)));
    for (int r = 0; r < 4; r++)
      run(16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h0180)),
          16'($urandom_range(0, 16'h0180)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
